// File: rtl/axi_apb_bridge_if.sv
// AXI4 slave + APB4 master signal bundle for axi_apb_bridge.
// slave modport is the bridge's view; master modport is the crossbar/peripheral side.
interface axi_apb_bridge_if #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int PADDR_W = 24
);
  logic              s_ar_valid, s_ar_ready;
  logic [ID_W-1:0]   s_ar_id;
  logic [ADDR_W-1:0] s_ar_addr;
  logic [7:0]        s_ar_len;
  logic [2:0]        s_ar_size;
  logic [1:0]        s_ar_burst;
  logic [2:0]        s_ar_prot;

  logic              s_r_valid, s_r_ready;
  logic [ID_W-1:0]   s_r_id;
  logic [31:0]       s_r_data;
  logic [1:0]        s_r_resp;
  logic              s_r_last;

  logic              s_aw_valid, s_aw_ready;
  logic [ID_W-1:0]   s_aw_id;
  logic [ADDR_W-1:0] s_aw_addr;
  logic [7:0]        s_aw_len;
  logic [2:0]        s_aw_size;
  logic [1:0]        s_aw_burst;
  logic [2:0]        s_aw_prot;

  logic              s_w_valid, s_w_ready;
  logic [31:0]       s_w_data;
  logic [3:0]        s_w_strb;
  logic              s_w_last;

  logic              s_b_valid, s_b_ready;
  logic [ID_W-1:0]   s_b_id;
  logic [1:0]        s_b_resp;

  logic              m_psel, m_penable, m_pwrite;
  logic [PADDR_W-1:0] m_paddr;
  logic [31:0]       m_pwdata;
  logic [3:0]        m_pstrb;
  logic [2:0]        m_pprot;
  logic              m_pready, m_pslverr;
  logic [31:0]       m_prdata;

  modport slave (
    input  s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_prot,
    output s_ar_ready,
    output s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
    input  s_r_ready,
    input  s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_prot,
    output s_aw_ready,
    input  s_w_valid, s_w_data, s_w_strb, s_w_last,
    output s_w_ready,
    output s_b_valid, s_b_id, s_b_resp,
    input  s_b_ready,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    input  m_pready, m_pslverr, m_prdata
  );

  modport master (
    output s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_prot,
    input  s_ar_ready,
    input  s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
    output s_r_ready,
    output s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_prot,
    input  s_aw_ready,
    output s_w_valid, s_w_data, s_w_strb, s_w_last,
    input  s_w_ready,
    input  s_b_valid, s_b_id, s_b_resp,
    output s_b_ready,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    output m_pready, m_pslverr, m_prdata
  );
endinterface

// File: rtl/axi_apb_bridge.sv
// AXI4 slave to APB4 master bridge: one burst in flight, one APB transfer per beat.
// Optional AXI_APB_BRIDGE_PSLVERR_EN maps pslverr onto R/B SLVERR responses.
module axi_apb_bridge #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int PADDR_W = 24
) (
  input logic             clk_gate,
  input logic             rst,
  axi_apb_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_ACCESS, RD_RESP, WR_DATA, WR_SETUP, WR_ACCESS, WR_RESP
  } state_t;

  state_t            state;
  logic              rd_first;
  logic [ID_W-1:0]   ax_id;
  logic [ADDR_W-1:0] ax_addr;
  logic [7:0]        ax_len;
  logic [2:0]        ax_size;
  logic [1:0]        ax_burst;
  logic [7:0]        beat_cnt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              last_beat;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
  logic              err_sticky;
`endif

  // Beat step is capped at 4 bytes (32-bit APB); WRAP advances like INCR without folding.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                 input logic [2:0] size,
                                                 input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    step = (size > 3'd2) ? ADDR_W'(4) : (ADDR_W'(1) << size);
    next_addr = (burst == 2'b00) ? addr : addr + step;
  endfunction

  assign addr_nxt  = next_addr(ax_addr, ax_size, ax_burst);
  assign last_beat = (beat_cnt == ax_len);

  logic unused_in;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
  assign unused_in = &{1'b0, bus.s_w_last};
`else
  assign unused_in = &{1'b0, bus.s_w_last, bus.m_pslverr};
`endif

  always_ff @(posedge clk_gate or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd_first       <= 1'b1;
      ax_id          <= '0;
      ax_addr        <= '0;
      ax_len         <= '0;
      ax_size        <= '0;
      ax_burst       <= '0;
      beat_cnt       <= '0;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
      err_sticky     <= 1'b0;
`endif
      bus.s_ar_ready <= 1'b0;
      bus.s_aw_ready <= 1'b0;
      bus.s_w_ready  <= 1'b0;
      bus.s_r_valid  <= 1'b0;
      bus.s_r_id     <= '0;
      bus.s_r_data   <= '0;
      bus.s_r_resp   <= '0;
      bus.s_r_last   <= 1'b0;
      bus.s_b_valid  <= 1'b0;
      bus.s_b_id     <= '0;
      bus.s_b_resp   <= '0;
      bus.m_psel     <= 1'b0;
      bus.m_penable  <= 1'b0;
      bus.m_pwrite   <= 1'b0;
      bus.m_paddr    <= '0;
      bus.m_pwdata   <= '0;
      bus.m_pstrb    <= '0;
      bus.m_pprot    <= '0;
    end else begin
      case (state)
        IDLE: begin
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
          err_sticky <= 1'b0;
`endif
          if (bus.s_ar_ready && bus.s_ar_valid) begin
            bus.s_ar_ready <= 1'b0;
            ax_id          <= bus.s_ar_id;
            ax_addr        <= bus.s_ar_addr;
            ax_len         <= bus.s_ar_len;
            ax_size        <= bus.s_ar_size;
            ax_burst       <= bus.s_ar_burst;
            bus.m_pprot    <= bus.s_ar_prot;
            beat_cnt       <= '0;
            rd_first       <= 1'b0;
            bus.m_psel     <= 1'b1;
            bus.m_pwrite   <= 1'b0;
            bus.m_paddr    <= bus.s_ar_addr[PADDR_W-1:0];
            state          <= RD_SETUP;
          end else if (bus.s_aw_ready && bus.s_aw_valid) begin
            bus.s_aw_ready <= 1'b0;
            ax_id          <= bus.s_aw_id;
            ax_addr        <= bus.s_aw_addr;
            ax_len         <= bus.s_aw_len;
            ax_size        <= bus.s_aw_size;
            ax_burst       <= bus.s_aw_burst;
            bus.m_pprot    <= bus.s_aw_prot;
            beat_cnt       <= '0;
            rd_first       <= 1'b1;
            bus.s_w_ready  <= 1'b1;
            state          <= WR_DATA;
          end else if (!bus.s_ar_ready && !bus.s_aw_ready) begin
            // Grant one side a cycle ahead so the two readies are never high together.
            if (bus.s_ar_valid && (!bus.s_aw_valid || rd_first))
              bus.s_ar_ready <= 1'b1;
            else if (bus.s_aw_valid)
              bus.s_aw_ready <= 1'b1;
          end
        end
        RD_SETUP: begin
          bus.m_penable <= 1'b1;
          state         <= RD_ACCESS;
        end
        RD_ACCESS: if (bus.m_pready) begin
          bus.m_psel    <= 1'b0;
          bus.m_penable <= 1'b0;
          bus.s_r_data  <= bus.m_prdata;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
          bus.s_r_resp  <= bus.m_pslverr ? 2'b10 : 2'b00;
`else
          bus.s_r_resp  <= 2'b00;
`endif
          bus.s_r_id    <= ax_id;
          bus.s_r_last  <= last_beat;
          bus.s_r_valid <= 1'b1;
          state         <= RD_RESP;
        end
        RD_RESP: if (bus.s_r_ready) begin
          bus.s_r_valid <= 1'b0;
          if (last_beat) begin
            state <= IDLE;
          end else begin
            beat_cnt    <= beat_cnt + 8'd1;
            ax_addr     <= addr_nxt;
            bus.m_paddr <= addr_nxt[PADDR_W-1:0];
            bus.m_psel  <= 1'b1;
            state       <= RD_SETUP;
          end
        end
        WR_DATA: if (bus.s_w_valid) begin
          bus.s_w_ready <= 1'b0;
          bus.m_pwdata  <= bus.s_w_data;
          bus.m_pstrb   <= bus.s_w_strb;
          bus.m_psel    <= 1'b1;
          bus.m_pwrite  <= 1'b1;
          bus.m_paddr   <= ax_addr[PADDR_W-1:0];
          state         <= WR_SETUP;
        end
        WR_SETUP: begin
          bus.m_penable <= 1'b1;
          state         <= WR_ACCESS;
        end
        WR_ACCESS: if (bus.m_pready) begin
          bus.m_psel    <= 1'b0;
          bus.m_penable <= 1'b0;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
          err_sticky    <= err_sticky | bus.m_pslverr;
`endif
          if (last_beat) begin
            bus.s_b_id    <= ax_id;
`ifdef AXI_APB_BRIDGE_PSLVERR_EN
            bus.s_b_resp  <= (err_sticky | bus.m_pslverr) ? 2'b10 : 2'b00;
`else
            bus.s_b_resp  <= 2'b00;
`endif
            bus.s_b_valid <= 1'b1;
            state         <= WR_RESP;
          end else begin
            beat_cnt      <= beat_cnt + 8'd1;
            ax_addr       <= addr_nxt;
            bus.s_w_ready <= 1'b1;
            state         <= WR_DATA;
          end
        end
        WR_RESP: if (bus.s_b_ready) begin
          bus.s_b_valid <= 1'b0;
          bus.m_pwrite  <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
